// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition search scheduler.
package acq_pkg;

    localparam int PRN_W             = 6;
    localparam int PHASE_W           = 11;
    localparam int CODE_BINS_DEFAULT = 2046;
    localparam int ENERGY_W_DEFAULT  = 24;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_LOAD,
        S_SETTLE,
        S_ARM,
        S_DWELL,
        S_WAIT_E,
        S_EVAL,
        S_DONE
    } acq_state_t;

    typedef struct packed {
        logic [PRN_W-1:0]            prn;
        logic [PHASE_W-1:0]          phase;
        logic [ENERGY_W_DEFAULT-1:0] energy;
    } hit_rec_t;

endpackage

// File: rtl/prn_mask_scan.sv
// Priority encoder: lowest set bit of the working PRN mask.
module prn_mask_scan #(
    parameter int NUM_PRN = 32
) (
    input  logic [NUM_PRN-1:0]         mask,
    output logic                       found,
    output logic [$clog2(NUM_PRN)-1:0] idx
);
    localparam int IDX_W = $clog2(NUM_PRN);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_PRN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/acq_search_sched.sv
// Acquisition search scheduler: walks enabled PRNs and half-chip code bins,
// sequencing generator reload/slip, correlator dwells and threshold tests.
//
// state  | meaning
// -------+----------------------------------------------------
// IDLE   | waiting for start
// SCAN   | pick lowest remaining PRN from the working mask
// LOAD   | gen_rst pulse, bin 0 of the selected PRN
// SETTLE | generator settling after reload or slip
// ARM    | wait for code epoch, clear correlator on it
// DWELL  | integrate DWELL_MS epochs
// WAIT_E | wait for correlator energy result
// EVAL   | threshold test: report hit, next bin or next PRN
// DONE   | done pulse, then back to IDLE
module acq_search_sched
    import acq_pkg::*;
#(
    parameter int NUM_PRN    = 32,
    parameter int CODE_BINS  = CODE_BINS_DEFAULT,
    parameter int DWELL_MS   = 1,
    parameter int SETTLE_CYC = 4,
    parameter int ENERGY_W   = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_PRN-1:0]  prn_mask,
    input  logic [ENERGY_W-1:0] threshold,
    input  logic                epoch,
    input  logic                energy_valid,
    input  logic [ENERGY_W-1:0] energy,
    output logic [PRN_W-1:0]    gen_prn,
    output logic                gen_rst,
    output logic                gen_slip,
    output logic                corr_clear,
    output logic                busy,
    output logic                hit_valid,
    output logic [PRN_W-1:0]    hit_prn,
    output logic [PHASE_W-1:0]  hit_phase,
    output logic [ENERGY_W-1:0] hit_energy,
    output logic                done
);
    localparam int IDX_W = $clog2(NUM_PRN);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [PHASE_W-1:0] LAST_BIN = PHASE_W'(CODE_BINS - 1);

    acq_state_t          state;
    logic [NUM_PRN-1:0]  mask_r;
    logic [ENERGY_W-1:0] thr_r;
    logic [ENERGY_W-1:0] energy_r;
    logic [PHASE_W-1:0]  phase_r;
    logic [IDX_W-1:0]    cur_idx;
    logic [IDX_W-1:0]    scan_idx;
    logic                scan_found;
    logic [SET_W-1:0]    settle_cnt;
    logic [3:0]          ep_cnt;
    hit_rec_t            hit_r;

    prn_mask_scan #(.NUM_PRN(NUM_PRN)) u_scan (
        .mask  (mask_r),
        .found (scan_found),
        .idx   (scan_idx)
    );

    assign hit_prn    = hit_r.prn;
    assign hit_phase  = hit_r.phase;
    assign hit_energy = ENERGY_W'(hit_r.energy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mask_r     <= '0;
            thr_r      <= '0;
            energy_r   <= '0;
            phase_r    <= '0;
            cur_idx    <= '0;
            settle_cnt <= '0;
            ep_cnt     <= '0;
            hit_r      <= '0;
            gen_prn    <= PRN_W'(1);
            gen_rst    <= 1'b0;
            gen_slip   <= 1'b0;
            corr_clear <= 1'b0;
            busy       <= 1'b0;
            hit_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            gen_rst    <= 1'b0;
            gen_slip   <= 1'b0;
            corr_clear <= 1'b0;
            hit_valid  <= 1'b0;
            done       <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            mask_r <= prn_mask;
                            thr_r  <= threshold;
                            busy   <= 1'b1;
                            state  <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (scan_found) begin
                            cur_idx <= scan_idx;
                            gen_prn <= PRN_W'(scan_idx) + PRN_W'(1);
                            phase_r <= '0;
                            gen_rst <= 1'b1;
                            state   <= S_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_LOAD: begin
                        settle_cnt <= SET_W'(SETTLE_CYC - 1);
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == '0) state <= S_ARM;
                        else settle_cnt <= settle_cnt - 1'b1;
                    end
                    S_ARM: begin
                        if (epoch) begin
                            corr_clear <= 1'b1;
                            ep_cnt     <= 4'(DWELL_MS - 1);
                            state      <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (epoch) begin
                            if (ep_cnt == 4'd0) state <= S_WAIT_E;
                            else ep_cnt <= ep_cnt - 4'd1;
                        end
                    end
                    S_WAIT_E: begin
                        if (energy_valid) begin
                            energy_r <= energy;
                            state    <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        if (energy_r >= thr_r) begin
                            hit_valid       <= 1'b1;
                            hit_r.prn       <= gen_prn;
                            hit_r.phase     <= phase_r;
                            hit_r.energy    <= ENERGY_W_DEFAULT'(energy_r);
                            mask_r[cur_idx] <= 1'b0;
                            state           <= S_SCAN;
                        end else if (phase_r == LAST_BIN) begin
                            mask_r[cur_idx] <= 1'b0;
                            state           <= S_SCAN;
                        end else begin
                            // The slip cycle itself is not part of the settle time.
                            phase_r    <= phase_r + 1'b1;
                            gen_slip   <= 1'b1;
                            settle_cnt <= SET_W'(SETTLE_CYC);
                            state      <= S_SETTLE;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_search_sched.sv
// Self-checking bench for acq_search_sched: event-queue model of the search order,
// behavioural generator/correlator, directed scenarios with literal expectations.
module tb_acq_search_sched;
    localparam int NUM_PRN    = 32;
    localparam int CODE_BINS  = 2046;
    localparam int DWELL_MS   = 1;
    localparam int SETTLE_CYC = 4;
    localparam int ENERGY_W   = 24;

    logic                clk = 1'b0;
    logic                rst, start, abort, epoch, energy_valid;
    logic [NUM_PRN-1:0]  prn_mask;
    logic [ENERGY_W-1:0] threshold, energy;
    logic [5:0]          gen_prn, hit_prn;
    logic                gen_rst, gen_slip, corr_clear, busy, hit_valid, done;
    logic [10:0]         hit_phase;
    logic [ENERGY_W-1:0] hit_energy;

    acq_search_sched #(
        .NUM_PRN(NUM_PRN), .CODE_BINS(CODE_BINS), .DWELL_MS(DWELL_MS),
        .SETTLE_CYC(SETTLE_CYC), .ENERGY_W(ENERGY_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prn_mask(prn_mask),
        .threshold(threshold), .epoch(epoch), .energy_valid(energy_valid), .energy(energy),
        .gen_prn(gen_prn), .gen_rst(gen_rst), .gen_slip(gen_slip), .corr_clear(corr_clear),
        .busy(busy), .hit_valid(hit_valid), .hit_prn(hit_prn), .hit_phase(hit_phase),
        .hit_energy(hit_energy), .done(done)
    );

    initial forever #5 clk = ~clk;

    // kind: 0 reload, 1 slip, 2 hit, 3 done
    typedef struct { int kind; int prn; int phase; int energy; } ev_t;
    ev_t exp_q[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int cfg_hit_prn, cfg_hit_phase, cfg_hit_energy, cfg_base;
    int exp_busy, exp_hit_prn, exp_hit_phase, exp_hit_energy;
    int n_rst, n_slip, n_hit, n_done, n_clr;
    int g_prn, g_phase;
    int dw_active, dw_ep, fire_ev, fire_energy, stray_req;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic int energy_of(input int prn, input int phase);
        return (prn == cfg_hit_prn && phase == cfg_hit_phase) ? cfg_hit_energy : cfg_base;
    endfunction

    // Expected generator/hit/done sequence for one full search.
    function automatic void build_expect(input logic [NUM_PRN-1:0] mask, input int thr);
        ev_t e;
        exp_q.delete();
        for (int p = 1; p <= NUM_PRN; p++) begin
            if (mask[p-1]) begin
                for (int ph = 0; ph < CODE_BINS; ph++) begin
                    e.kind = (ph == 0) ? 0 : 1;
                    e.prn = p; e.phase = ph; e.energy = 0;
                    exp_q.push_back(e);
                    if (energy_of(p, ph) >= thr) begin
                        e.kind = 2; e.energy = energy_of(p, ph);
                        exp_q.push_back(e);
                        break;
                    end
                end
            end
        end
        e.kind = 3; e.prn = 0; e.phase = 0; e.energy = 0;
        exp_q.push_back(e);
    endfunction

    task automatic expect_ev(input string nm, input int kind, input int prn, input int phase, input int en);
        ev_t e;
        check({nm, "_queued"}, int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({nm, "_kind"}, kind, e.kind);
            if (kind != 3) check({nm, "_prn"}, prn, e.prn);
            if (kind == 1 || kind == 2) check({nm, "_phase"}, phase, e.phase);
            if (kind == 2) begin
                check({nm, "_energy"}, en, e.energy);
                exp_hit_prn = e.prn; exp_hit_phase = e.phase; exp_hit_energy = e.energy;
            end
        end
    endtask

    task automatic check_cycle();
        check("pulse_overlap", int'(gen_rst) + int'(gen_slip) + int'(corr_clear) > 1 ? 1 : 0, 0);
        check("busy", int'(busy), exp_busy);
        if (gen_rst) begin
            n_rst++; g_prn = int'(gen_prn); g_phase = 0;
            expect_ev("gen_rst", 0, int'(gen_prn), 0, 0);
        end
        if (gen_slip) begin
            n_slip++; g_phase++;
            expect_ev("gen_slip", 1, int'(gen_prn), g_phase, 0);
        end
        if (hit_valid) begin
            n_hit++;
            expect_ev("hit", 2, int'(hit_prn), int'(hit_phase), int'(hit_energy));
        end
        if (done) begin
            n_done++;
            expect_ev("done", 3, 0, 0, 0);
        end
        check("hold_prn", int'(hit_prn), exp_hit_prn);
        check("hold_phase", int'(hit_phase), exp_hit_phase);
        check("hold_energy", int'(hit_energy), exp_hit_energy);
        if (corr_clear) begin
            n_clr++; dw_active = 1; dw_ep = 0;
        end
        if (dw_active && epoch) dw_ep++;
        if (dw_active && dw_ep == DWELL_MS) begin
            dw_active = 0; fire_ev = 1; fire_energy = energy_of(g_prn, g_phase);
        end
        if (abort) begin
            if (exp_busy != 0) exp_q.delete();
            exp_busy = 0;
        end else if (start && exp_busy == 0) begin
            build_expect(prn_mask, int'(threshold));
            exp_busy = 1;
        end else if (done) begin
            exp_busy = 0;
        end
    endtask

    // Epoch source, correlator/generator model and per-cycle compare.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            epoch = (cyc % 2 == 0);
            energy_valid = (fire_ev != 0) || (stray_req != 0);
            energy = (stray_req != 0) ? 24'hFFFFFF : ENERGY_W'(fire_energy);
            fire_ev = 0; stray_req = 0;
            @(negedge clk);
            if (rst) dw_active = 0;
            else check_cycle();
        end
    end

    task automatic clr_counts();
        n_rst = 0; n_slip = 0; n_hit = 0; n_done = 0; n_clr = 0; g_prn = 0; g_phase = 0;
    endtask

    task automatic set_cfg(input int hp, input int hph, input int he, input int base);
        cfg_hit_prn = hp; cfg_hit_phase = hph; cfg_hit_energy = he; cfg_base = base;
    endtask

    task automatic issue_start(input logic [NUM_PRN-1:0] m, input logic [ENERGY_W-1:0] t);
        @(posedge clk); #1;
        start = 1'b1; prn_mask = m; threshold = t;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((exp_busy != 0 || busy) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({nm, "_timeout"}, int'(n >= budget), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; prn_mask = '0; threshold = '0;
        epoch = 1'b0; energy_valid = 1'b0; energy = '0;
        exp_busy = 0; exp_hit_prn = 0; exp_hit_phase = 0; exp_hit_energy = 0;
        dw_active = 0; dw_ep = 0; fire_ev = 0; fire_energy = 0; stray_req = 0;
        set_cfg(0, 0, 0, 0);
        clr_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gen_prn", int'(gen_prn), 1);
        check("rst_pulses", int'({gen_rst, gen_slip, corr_clear, hit_valid, done}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_hit_prn", int'(hit_prn), 0);
        check("rst_hit_phase", int'(hit_phase), 0);
        check("rst_hit_energy", int'(hit_energy), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full sweep of PRN1 and PRN3 with no detection.
        set_cfg(0, 0, 0, 0); clr_counts();
        issue_start(32'h0000_0005, 24'hFFFFFF);
        wait_idle("sweep", 60000);
        check("sweep_rst", n_rst, 2);
        check("sweep_slip", n_slip, 4090);
        check("sweep_clr", n_clr, 4092);
        check("sweep_hit", n_hit, 0);
        check("sweep_done", n_done, 1);

        // Detection on PRN2 bin 7.
        set_cfg(2, 7, 150, 0); clr_counts();
        issue_start(32'h0000_0002, 24'd100);
        wait_idle("hit7", 2000);
        check("hit7_slip", n_slip, 7);
        check("hit7_count", n_hit, 1);
        check("hit7_prn", int'(hit_prn), 2);
        check("hit7_phase", int'(hit_phase), 7);
        check("hit7_energy", int'(hit_energy), 150);
        check("hit7_done", n_done, 1);

        // Empty mask: done two cycles after start.
        clr_counts();
        @(posedge clk); #1; start = 1'b1; prn_mask = '0;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); #1;
        check("empty_busy1", int'(busy), 1); check("empty_done1", int'(done), 0);
        @(negedge clk); #1;
        check("empty_busy2", int'(busy), 1); check("empty_done2", int'(done), 1);
        @(negedge clk); #1;
        check("empty_busy3", int'(busy), 0); check("empty_done3", int'(done), 0);
        check("empty_rst", n_rst, 0);

        // start and abort together in IDLE.
        @(posedge clk); #1; start = 1'b1; abort = 1'b1; prn_mask = 32'h1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        check("startabort_busy", int'(busy), 0);
        check("startabort_rst", n_rst, 0);

        // Abort during the dwell of PRN1 bin 3, then restart from bin 0.
        set_cfg(0, 0, 0, 0); clr_counts();
        issue_start(32'h1, 24'hFFFFFF);
        n = 0;
        while (!(g_prn == 1 && g_phase == 3 && dw_active != 0) && n < 500) begin
            @(negedge clk); #1; n++;
        end
        check("abort_reach_timeout", int'(n >= 500), 0);
        check("abort_busy_before", int'(busy), 1);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk); #1;
        check("abort_busy_after", int'(busy), 0);
        repeat (10) begin @(negedge clk); #1; end
        check("abort_done", n_done, 0);
        check("abort_hit", n_hit, 0);
        set_cfg(1, 2, 150, 0); clr_counts();
        issue_start(32'h1, 24'd100);
        wait_idle("restart", 1000);
        check("restart_rst", n_rst, 1);
        check("restart_slip", n_slip, 2);
        check("restart_phase", int'(hit_phase), 2);
        check("restart_done", n_done, 1);

        // start re-pulse while busy and stray energy_valid in SETTLE are ignored.
        set_cfg(3, 3, 200, 0); clr_counts();
        issue_start(32'h4, 24'd100);
        n = 0;
        while (n_rst == 0 && n < 100) begin @(negedge clk); #1; n++; end
        check("stray_reach_timeout", int'(n >= 100), 0);
        stray_req = 1;
        @(posedge clk); #1; start = 1'b1; prn_mask = '1;
        @(posedge clk); #1; start = 1'b0;
        wait_idle("stray", 1000);
        check("stray_rst", n_rst, 1);
        check("stray_slip", n_slip, 3);
        check("stray_hit_prn", int'(hit_prn), 3);
        check("stray_hit_phase", int'(hit_phase), 3);
        check("stray_hit_energy", int'(hit_energy), 200);
        check("stray_done", n_done, 1);

        // energy equal to threshold is a hit; one below is not.
        set_cfg(1, 1, 24'h000400, 24'h0003FF); clr_counts();
        issue_start(32'h1, 24'h000400);
        wait_idle("eq", 1000);
        check("eq_slip", n_slip, 1);
        check("eq_hit_phase", int'(hit_phase), 1);
        check("eq_hit_energy", int'(hit_energy), 32'h400);

        // Asynchronous reset in WAIT_E.
        set_cfg(0, 0, 0, 24'h0003FF); clr_counts();
        issue_start(32'h1, 24'h000400);
        n = 0;
        while (!(fire_ev != 0 && g_phase == 2) && n < 500) begin @(negedge clk); #1; n++; end
        check("arst_reach_timeout", int'(n >= 500), 0);
        #6;
        check("arst_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        exp_q.delete(); exp_busy = 0;
        exp_hit_prn = 0; exp_hit_phase = 0; exp_hit_energy = 0;
        check("arst_gen_prn", int'(gen_prn), 1);
        check("arst_pulses", int'({gen_rst, gen_slip, corr_clear, hit_valid, done}), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_hit_prn", int'(hit_prn), 0);
        check("arst_hit_phase", int'(hit_phase), 0);
        check("arst_hit_energy", int'(hit_energy), 0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (5) begin @(negedge clk); #1; end
        check("arst_idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
